// File: rtl/config_pkg.sv
// Shared GPIO CSR definitions: address type, register map and CSR funct3 encodings.
// Build option GPIO_DEBOUNCE_EN (see gpio_debounce) does not affect this package.
package config_pkg;

    typedef logic [11:0] CsrAddrT;

    localparam CsrAddrT GpioBaseAddr = 12'h003;
    localparam CsrAddrT GpioDirOff   = 12'h000;
    localparam CsrAddrT GpioOutOff   = 12'h001;
    localparam CsrAddrT GpioInOff    = 12'h002;
    localparam CsrAddrT GpioPendOff  = 12'h003;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } CsrOpT;

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin 2-flop synchronizer, stable-value filter and rising-edge detect.
// Build option GPIO_DEBOUNCE_EN: when defined, a change must persist DebounceCycles cycles; otherwise one extra flop.
module gpio_debounce #(
    parameter int unsigned DebounceCycles = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_o
);

    if ((DebounceCycles < 2) || (DebounceCycles > 65535)) begin : g_bad_cycles
        $error("gpio_debounce: DebounceCycles out of range");
    end

    logic [1:0] sync_q;
    logic       stable_q;
    logic       stable_d;

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DebounceCycles);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Counter runs only while the synchronized value disagrees with the accepted one
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DebounceCycles - 1)) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Debounce counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without filtering the accepted value is just the synchronizer delayed once
    always_comb begin
        stable_d = sync_q[1];
    end
`endif

    // Synchronizer and accepted-value registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], pin_i};
            stable_q <= stable_d;
        end
    end

    // Rise is flagged for the edge on which stable_q itself goes high
    assign rise_o   = stable_d & ~stable_q;
    assign stable_o = stable_q;

endmodule

// File: rtl/gpio_csr.sv
// GPIO block with DIR/OUT/IN/PEND CSRs, sticky rising-edge pending bits and a level irq.
// Build option GPIO_DEBOUNCE_EN selects counter-based input debouncing in gpio_debounce.
module gpio_csr
    import config_pkg::*;
#(
    parameter int unsigned Width          = 8,
    parameter int unsigned DebounceCycles = 16,
    parameter CsrAddrT     BaseAddr       = GpioBaseAddr
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             csr_enable,
    input  CsrAddrT          csr_addr,
    input  logic [2:0]       csr_op,
    input  logic [4:0]       rs1_zimm,
    input  logic [31:0]      rs1_data,
    output logic [31:0]      csr_out,
    input  logic [Width-1:0] gpio_i,
    output logic [Width-1:0] gpio_o,
    output logic [Width-1:0] gpio_oe,
    output logic             irq
);

    logic [Width-1:0] dir_q, dir_d, out_q, out_d, pend_q, pend_d;
    logic [Width-1:0] stable_s, rise_s, old_s, new_s, opw_s;
    logic [31:0]      operand_s, rdata_s;
    logic             wr_en_s, sel_dir_s, sel_out_s, sel_in_s, sel_pend_s;

    for (genvar i = 0; i < Width; i++) begin : g_pin
        gpio_debounce #(
            .DebounceCycles(DebounceCycles)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .pin_i   (gpio_i[i]),
            .stable_o(stable_s[i]),
            .rise_o  (rise_s[i])
        );
    end

    assign sel_dir_s  = csr_enable && (csr_addr == BaseAddr + GpioDirOff);
    assign sel_out_s  = csr_enable && (csr_addr == BaseAddr + GpioOutOff);
    assign sel_in_s   = csr_enable && (csr_addr == BaseAddr + GpioInOff);
    assign sel_pend_s = csr_enable && (csr_addr == BaseAddr + GpioPendOff);

    // Read mux: pre-write value of the addressed register, zero when nothing is hit
    always_comb begin
        if (sel_dir_s) begin
            old_s = dir_q;
        end else if (sel_out_s) begin
            old_s = out_q;
        end else if (sel_in_s) begin
            old_s = stable_s;
        end else if (sel_pend_s) begin
            old_s = pend_q;
        end else begin
            old_s = '0;
        end
        rdata_s              = 32'd0;
        rdata_s[Width-1:0]   = old_s;
    end

    // Operand select and read-modify-write; set/clear with a zero operand never writes
    always_comb begin
        operand_s = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
        opw_s     = operand_s[Width-1:0];
        new_s     = old_s;
        wr_en_s   = 1'b0;
        case (csr_op)
            CSR_RW, CSR_RWI: begin
                new_s   = opw_s;
                wr_en_s = 1'b1;
            end
            CSR_RS, CSR_RSI: begin
                new_s   = old_s | opw_s;
                wr_en_s = (operand_s != 32'd0);
            end
            CSR_RC, CSR_RCI: begin
                new_s   = old_s & ~opw_s;
                wr_en_s = (operand_s != 32'd0);
            end
            default: begin
                new_s   = old_s;
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Register next state; a pending set on an input pin beats a same-edge clear
    always_comb begin
        if (wr_en_s && sel_dir_s) begin
            dir_d = new_s;
        end else begin
            dir_d = dir_q;
        end
        if (wr_en_s && sel_out_s) begin
            out_d = new_s;
        end else begin
            out_d = out_q;
        end
        if (wr_en_s && sel_pend_s) begin
            pend_d = new_s | (rise_s & ~dir_q);
        end else begin
            pend_d = pend_q | (rise_s & ~dir_q);
        end
    end

    // CSR state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q  <= '0;
            out_q  <= '0;
            pend_q <= '0;
        end else begin
            dir_q  <= dir_d;
            out_q  <= out_d;
            pend_q <= pend_d;
        end
    end

    assign csr_out = rdata_s;
    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign irq     = |pend_q;

endmodule

// File: tb/tb_gpio_csr.sv
// Directed self-checking bench for gpio_csr at default parameters (Width 8, BaseAddr 0x003).
// Input latency expectations follow GPIO_DEBOUNCE_EN: 2+16 cycles when defined, 3 otherwise.
module tb_gpio_csr;

    localparam logic [11:0] A_DIR  = 12'h003;
    localparam logic [11:0] A_OUT  = 12'h004;
    localparam logic [11:0] A_IN   = 12'h005;
    localparam logic [11:0] A_PEND = 12'h006;
    localparam logic [2:0]  OP_RW = 3'b001, OP_RS = 3'b010, OP_RC = 3'b011;
    localparam logic [2:0]  OP_RWI = 3'b101, OP_RSI = 3'b110, OP_RCI = 3'b111;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 18;
    localparam logic [31:0] GLITCH_PEND = 32'h01;
`else
    localparam int LAT = 3;
    localparam logic [31:0] GLITCH_PEND = 32'h03;
`endif

    logic        clk = 1'b0;
    logic        reset, csr_enable, irq;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [4:0]  rs1_zimm;
    logic [31:0] rs1_data, csr_out, rd;
    logic [7:0]  gpio_i, gpio_o, gpio_oe;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpio_csr dut (
        .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
        .csr_op(csr_op), .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .csr_out(csr_out),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] data,
                       input logic [4:0] zimm, output logic [31:0] rdata);
        csr_enable = 1'b1; csr_op = op; csr_addr = addr; rs1_data = data; rs1_zimm = zimm;
        #1;
        rdata = csr_out;
        @(posedge clk);
        #1;
        csr_enable = 1'b0; csr_op = 3'b000; rs1_data = 32'd0; rs1_zimm = 5'd0;
    endtask

    // Non-destructive read: CSRRSI with zimm=0, no clock edge consumed
    task automatic peek(input logic [11:0] addr, output logic [31:0] rdata);
        csr_enable = 1'b1; csr_op = OP_RSI; rs1_zimm = 5'd0; csr_addr = addr;
        #1;
        rdata = csr_out;
        csr_enable = 1'b0;
    endtask

    initial begin
        gpio_i = 8'h00; csr_addr = A_DIR; csr_op = 3'b000; rs1_zimm = 5'd0; rs1_data = 32'd0;
        // Reset with a concurrent DIR write that must be ignored
        reset = 1'b1; csr_enable = 1'b1; csr_op = OP_RW; rs1_data = 32'hFF;
        tick(2);
        csr_enable = 1'b0;
        check_eq("rst_oe", gpio_oe, 32'h00);
        check_eq("rst_o", gpio_o, 32'h00);
        check_eq("rst_irq", irq, 32'h0);
        peek(A_DIR, rd);  check_eq("rst_dir", rd, 32'h00);
        reset = 1'b0;
        tick(1);

        csr(OP_RW, A_DIR, 32'hF0, 5'd0, rd); check_eq("dir_wr_old", rd, 32'h00);
        check_eq("oe_f0", gpio_oe, 32'hF0);
        csr(OP_RW, A_OUT, 32'hA5, 5'd0, rd); check_eq("out_wr_old", rd, 32'h00);
        check_eq("o_a5", gpio_o, 32'hA5);

        // Pin 0 rising edge latency
        gpio_i = 8'h01;
        tick(LAT - 1);
        peek(A_IN, rd);   check_eq("in0_early", rd, 32'h00);
        check_eq("irq_early", irq, 32'h0);
        tick(1);
        peek(A_IN, rd);   check_eq("in0_set", rd, 32'h01);
        peek(A_PEND, rd); check_eq("pend0_set", rd, 32'h01);
        check_eq("irq_set", irq, 32'h1);

        // 10-cycle glitch on pin 1
        gpio_i = 8'h03;
        tick(10);
        gpio_i = 8'h01;
        tick(LAT + 4);
        peek(A_IN, rd);   check_eq("glitch_in", rd, 32'h01);
        peek(A_PEND, rd); check_eq("glitch_pend", rd, GLITCH_PEND);
        csr(OP_RC, A_PEND, 32'h02, 5'd0, rd); check_eq("pend_rc_old", rd, GLITCH_PEND);
        peek(A_PEND, rd); check_eq("pend_rc", rd, 32'h01);

        // Pin 0 falls, then rises again with a coincident clear
        gpio_i = 8'h00;
        tick(LAT + 2);
        peek(A_IN, rd);   check_eq("in0_fall", rd, 32'h00);
        peek(A_PEND, rd); check_eq("pend_fall", rd, 32'h01);
        gpio_i = 8'h01;
        tick(LAT - 1);
        peek(A_IN, rd);   check_eq("in0_pre", rd, 32'h00);
        csr(OP_RCI, A_PEND, 32'd0, 5'd1, rd); check_eq("pend_rci_old", rd, 32'h01);
        peek(A_PEND, rd); check_eq("pend_set_wins", rd, 32'h01);
        peek(A_IN, rd);   check_eq("in0_again", rd, 32'h01);
        csr(OP_RCI, A_PEND, 32'd0, 5'd1, rd);
        check_eq("irq_clr", irq, 32'h0);
        peek(A_PEND, rd); check_eq("pend_clr", rd, 32'h00);

        // Rise on an output pin (DIR[4]=1) sets no pending bit
        gpio_i = 8'h11;
        tick(LAT + 2);
        peek(A_IN, rd);   check_eq("in_out_pin", rd, 32'h11);
        peek(A_PEND, rd); check_eq("pend_out_pin", rd, 32'h00);

        // Zero-operand set, read-only IN, operand width and unknown op
        csr(OP_RSI, A_DIR, 32'd0, 5'd0, rd); check_eq("rsi0_old", rd, 32'hF0);
        peek(A_DIR, rd);  check_eq("rsi0_dir", rd, 32'hF0);
        csr(OP_RW, A_IN, 32'hFFFFFFFF, 5'd0, rd); check_eq("in_wr_old", rd, 32'h11);
        peek(A_IN, rd);   check_eq("in_ro", rd, 32'h11);
        csr(OP_RW, A_OUT, 32'hFFFFFF3C, 5'd0, rd); check_eq("out_old_a5", rd, 32'hA5);
        peek(A_OUT, rd);  check_eq("out_trunc", rd, 32'h3C);
        csr(OP_RS, A_OUT, 32'h03, 5'd0, rd);
        peek(A_OUT, rd);  check_eq("out_rs", rd, 32'h3F);
        csr(OP_RC, A_OUT, 32'h30, 5'd0, rd);
        peek(A_OUT, rd);  check_eq("out_rc", rd, 32'h0F);
        csr(OP_RWI, A_OUT, 32'hFF, 5'h1F, rd);
        peek(A_OUT, rd);  check_eq("out_rwi", rd, 32'h1F);
        csr(3'b100, A_OUT, 32'hFF, 5'h00, rd);
        peek(A_OUT, rd);  check_eq("out_bad_op", rd, 32'h1F);
        csr(OP_RCI, A_OUT, 32'hFF, 5'h03, rd);
        check_eq("o_rci", gpio_o, 32'h1C);
        peek(12'h007, rd); check_eq("miss_addr", rd, 32'h00);
        csr_enable = 1'b0; csr_addr = A_DIR; #1;
        check_eq("no_enable", csr_out, 32'h00);

        // Reset in the middle of a debounce run
        gpio_i = 8'h00;
        tick(LAT + 2);
        gpio_i = 8'h04;
        tick(11);
        reset = 1'b1;
        tick(1);
        check_eq("mid_rst_oe", gpio_oe, 32'h00);
        check_eq("mid_rst_o", gpio_o, 32'h00);
        check_eq("mid_rst_irq", irq, 32'h0);
        peek(A_IN, rd);   check_eq("mid_rst_in", rd, 32'h00);
        reset = 1'b0;
        tick(LAT - 1);
        peek(A_IN, rd);   check_eq("post_rst_early", rd, 32'h00);
        tick(1);
        peek(A_IN, rd);   check_eq("post_rst_in", rd, 32'h04);
        check_eq("post_rst_irq", irq, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
